instr_encoder_loader: RTL and testbench

- Encoder/loader counterpart to the opcode decoder: takes symbolic instruction fields (mnemonic index, register numbers, immediate/target) and assembles 32-bit MIPS words.
- Writes each word sequentially into instruction memory through a simple write port, then terminates the program with a HALT word.
- Sits between the debug/UART command path and the instruction memory. It is used to load programs before the pipeline runs.

---
 rtl/instr_encoder_loader.sv | 172 +++++++++++++++++
 tb/tb_instr_encoder_loader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// Assembles symbolic instruction fields into 32-bit MIPS words and streams them
// into instruction memory, closing the program with a HALT terminator word.
module instr_encoder_loader #(
  parameter int                 NB_OP     = 6,
  parameter int                 NB_DATA   = 32,
  parameter int                 NB_ADDR   = 8,
  parameter logic [NB_DATA-1:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [4:0]         i_mnemonic,
  input  logic [4:0]         i_rs,
  input  logic [4:0]         i_rt,
  input  logic [4:0]         i_rd,
  input  logic [4:0]         i_shamt,
  input  logic [15:0]        i_imm,
  input  logic [25:0]        i_target,
  input  logic               i_done,
  output logic               o_imem_we,
  output logic [NB_ADDR-1:0] o_imem_addr,
  output logic [NB_DATA-1:0] o_imem_data,
  output logic [NB_ADDR-1:0] o_count,
  output logic               o_busy,
  output logic               o_load_done,
  output logic               o_error
);

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, HALT, DONE} state_t;

  localparam logic [NB_ADDR-1:0] LAST_SLOT = {NB_ADDR{1'b1}};

  state_t               state, next_state;
  logic [NB_ADDR-1:0]   count, addr;
  logic [NB_DATA-1:0]   data, enc;
  logic                 error, legal, accept;
  logic [NB_OP-1:0]     op, funct;
  logic [4:0]           rs_f, rt_f, rd_f, sh_f;
  logic                 is_shift, is_rtype, is_jtype;

  always_comb begin
    op       = '0;
    funct    = '0;
    legal    = 1'b1;
    enc      = '0;
    case (i_mnemonic)
      5'd0:  funct = 6'b100001;
      5'd1:  funct = 6'b100011;
      5'd2:  funct = 6'b100100;
      5'd3:  funct = 6'b100101;
      5'd4:  funct = 6'b100110;
      5'd5:  funct = 6'b100111;
      5'd6:  funct = 6'b101010;
      5'd7:  funct = 6'b000000;
      5'd8:  funct = 6'b000010;
      5'd9:  funct = 6'b000011;
      5'd10: funct = 6'b001000;
      5'd11: funct = 6'b001001;
      5'd12: op = 6'b100011;
      5'd13: op = 6'b101011;
      5'd14: op = 6'b000100;
      5'd15: op = 6'b000101;
      5'd16: op = 6'b001000;
      5'd17: op = 6'b000010;
      5'd18: op = 6'b000011;
      5'd19: op = 6'b100000;
      5'd20: op = 6'b100001;
      5'd21: op = 6'b100100;
      5'd22: op = 6'b100101;
      5'd23: op = 6'b100111;
      5'd24: op = 6'b101000;
      5'd25: op = 6'b101001;
      5'd26: op = 6'b001101;
      5'd27: op = 6'b001110;
      5'd28: op = 6'b001111;
      5'd29: op = 6'b001010;
      5'd30: op = 6'b001100;
      default: legal = 1'b0;
    endcase
    is_shift = (i_mnemonic == 5'd7) || (i_mnemonic == 5'd8) || (i_mnemonic == 5'd9);
    is_rtype = (i_mnemonic <= 5'd11);
    is_jtype = (i_mnemonic == 5'd17) || (i_mnemonic == 5'd18);
    // Field zeroing: shifts and LUI have no rs; JR/JALR have no rt; JR has no rd
    rs_f = (is_shift || i_mnemonic == 5'd28) ? 5'd0 : i_rs;
    rt_f = (i_mnemonic == 5'd10 || i_mnemonic == 5'd11) ? 5'd0 : i_rt;
    rd_f = (i_mnemonic == 5'd10) ? 5'd0 : i_rd;
    sh_f = is_shift ? i_shamt : 5'd0;
    if (is_rtype)      enc = {op, rs_f, rt_f, rd_f, sh_f, funct};
    else if (is_jtype) enc = {op, i_target};
    else               enc = {op, rs_f, rt_f, i_imm};
  end

  always_ff @(posedge clk) begin
    if (i_rst) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state  = state;
    o_ready     = (state == LOAD) && (count != LAST_SLOT);
    o_imem_we   = (state == WRITE) || (state == HALT);
    o_busy      = (state == LOAD) || (state == WRITE) || (state == HALT);
    o_load_done = (state == DONE);
    accept      = i_valid && o_ready;
    case (state)
      IDLE:  if (i_start) next_state = LOAD;
      LOAD: begin
        if (i_start)     next_state = LOAD;
        else if (accept) next_state = legal ? WRITE : LOAD;
        else if (i_done) next_state = HALT;
      end
      WRITE: next_state = LOAD;
      HALT:  next_state = i_start ? LOAD : DONE;
      DONE:  if (i_start) next_state = LOAD;
      default: next_state = IDLE;
    endcase
  end

  // A start seen during WRITE lets the write finish, then restarts on the way back to LOAD
  always_ff @(posedge clk) begin
    if (i_rst) begin
      count <= '0;
      error <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else begin
      case (state)
        WRITE: begin
          if (i_start) begin
            count <= '0;
            error <= 1'b0;
          end else begin
            count <= count + 1'b1;
          end
        end
        LOAD: begin
          if (i_start) begin
            count <= '0;
            error <= 1'b0;
          end else if (accept) begin
            if (!legal) begin
              error <= 1'b1;
            end else begin
              data <= enc;
              addr <= count;
            end
          end else begin
            if (i_valid) error <= 1'b1;
            if (i_done) begin
              addr <= count;
              data <= HALT_WORD;
            end
          end
        end
        default: begin
          if (i_start) begin
            count <= '0;
            error <= 1'b0;
          end
        end
      endcase
    end
  end

  assign o_imem_addr = addr;
  assign o_imem_data = data;
  assign o_count     = count;
  assign o_error     = error;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench: directed scenarios plus randomized programs compared against
// an arithmetic reference encoder; a second NB_ADDR=2 instance covers overflow.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        i_rst, i_start, i_valid, i_done;
  logic [4:0]  i_mnemonic, i_rs, i_rt, i_rd, i_shamt;
  logic [15:0] i_imm;
  logic [25:0] i_target;

  logic        ready, we, busy, load_done, error;
  logic [7:0]  addr, count;
  logic [31:0] data;

  logic        s_ready, s_we, s_busy, s_load_done, s_error;
  logic [1:0]  s_addr, s_count;
  logic [31:0] s_data;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] HALT = 32'hFFFFFFFF;

  always #5 clk = ~clk;

  instr_encoder_loader dut (
    .clk(clk), .i_rst(i_rst), .i_start(i_start), .i_valid(i_valid), .o_ready(ready),
    .i_mnemonic(i_mnemonic), .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd), .i_shamt(i_shamt),
    .i_imm(i_imm), .i_target(i_target), .i_done(i_done), .o_imem_we(we),
    .o_imem_addr(addr), .o_imem_data(data), .o_count(count), .o_busy(busy),
    .o_load_done(load_done), .o_error(error)
  );

  instr_encoder_loader #(.NB_ADDR(2)) dut_small (
    .clk(clk), .i_rst(i_rst), .i_start(i_start), .i_valid(i_valid), .o_ready(s_ready),
    .i_mnemonic(i_mnemonic), .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd), .i_shamt(i_shamt),
    .i_imm(i_imm), .i_target(i_target), .i_done(i_done), .o_imem_we(s_we),
    .o_imem_addr(s_addr), .o_imem_data(s_data), .o_count(s_count), .o_busy(s_busy),
    .o_load_done(s_load_done), .o_error(s_error)
  );

  // Reference encoder built from the opcode/funct tables with shifts and ORs
  function automatic logic [31:0] ref_encode(input int mn, input logic [4:0] rs, rt, rd, sh,
                                             input logic [15:0] imm, input logic [25:0] tgt);
    int funct_tab[12] = '{33, 35, 36, 37, 38, 39, 42, 0, 2, 3, 8, 9};
    int op_tab[19]    = '{35, 43, 4, 5, 8, 2, 3, 32, 33, 36, 37, 39, 40, 41, 13, 14, 15, 10, 12};
    logic [31:0] w;
    if (mn < 12) begin
      w = 32'(funct_tab[mn]);
      if (!(mn inside {7, 8, 9})) w = w | (32'(rs) << 21);
      if (mn != 10 && mn != 11)   w = w | (32'(rt) << 16);
      if (mn != 10)               w = w | (32'(rd) << 11);
      if (mn inside {7, 8, 9})    w = w | (32'(sh) << 6);
    end else if (mn == 17 || mn == 18) begin
      w = (32'(op_tab[mn-12]) << 26) | 32'(tgt);
    end else begin
      w = (32'(op_tab[mn-12]) << 26) | (32'(rt) << 16) | 32'(imm);
      if (mn != 28) w = w | (32'(rs) << 21);
    end
    return w;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    @(negedge clk); i_start = 1'b1;
    @(posedge clk); #1; i_start = 1'b0;
  endtask

  // Presents one instruction for a single cycle; returns 1 time unit after the accepting edge
  task automatic issue(input logic [4:0] mn, rs, rt, rd, sh, input logic [15:0] imm,
                       input logic [25:0] tgt);
    @(negedge clk);
    i_mnemonic = mn; i_rs = rs; i_rt = rt; i_rd = rd; i_shamt = sh; i_imm = imm; i_target = tgt;
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_start = 1'b0; i_valid = 1'b0; i_done = 1'b0;
    i_mnemonic = '0; i_rs = '0; i_rt = '0; i_rd = '0; i_shamt = '0; i_imm = '0; i_target = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({ready, we, busy, load_done, error} !== 5'b0) begin errors++; $display("[TB] FAIL reset_flags got %b want 00000", {ready, we, busy, load_done, error}); end
    checks++; if ({addr, count, data} !== 48'h0) begin errors++; $display("[TB] FAIL reset_regs got %h want 0", {addr, count, data}); end
    @(negedge clk); i_rst = 1'b0;
    step();
    checks++; if ({busy, ready, s_busy} !== 3'b000) begin errors++; $display("[TB] FAIL idle_after_reset got %b want 000", {busy, ready, s_busy}); end
  endtask

  task automatic test_encode();
    pulse_start();
    checks++; if ({busy, ready, count} !== {2'b11, 8'd0}) begin errors++; $display("[TB] FAIL start_load got %b/%b/%0d want 1/1/0", busy, ready, count); end
    issue(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    checks++; if ({we, addr, data} !== {1'b1, 8'd0, 32'h00221821}) begin errors++; $display("[TB] FAIL addu_write got %b@%0d %h want 1@0 00221821", we, addr, data); end
    step();
    checks++; if ({we, count} !== {1'b0, 8'd1}) begin errors++; $display("[TB] FAIL addu_count got we=%b cnt=%0d want 0/1", we, count); end
    issue(5'd12, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0);
    checks++; if ({we, addr, data} !== {1'b1, 8'd1, 32'h8FA80004}) begin errors++; $display("[TB] FAIL lw_write got %b@%0d %h want 1@1 8FA80004", we, addr, data); end
    step();
    issue(5'd14, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0);
    checks++; if ({addr, data} !== {8'd2, 32'h1022FFFF}) begin errors++; $display("[TB] FAIL beq_write got @%0d %h want @2 1022FFFF", addr, data); end
    step();
    issue(5'd7, 5'd7, 5'd5, 5'd4, 5'd2, 16'h0, 26'h0);
    checks++; if (data !== 32'h00052080) begin errors++; $display("[TB] FAIL sll_write got %h want 00052080", data); end
    step();
    issue(5'd17, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10);
    checks++; if (data !== 32'h08000010) begin errors++; $display("[TB] FAIL j_write got %h want 08000010", data); end
    step();
    checks++; if (count !== 8'd5) begin errors++; $display("[TB] FAIL encode_count got %0d want 5", count); end
  endtask

  task automatic test_illegal();
    pulse_start();
    issue(5'd31, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    checks++; if ({we, error, count} !== {2'b01, 8'd0}) begin errors++; $display("[TB] FAIL illegal got we=%b err=%b cnt=%0d want 0/1/0", we, error, count); end
    issue(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    checks++; if ({we, addr, data} !== {1'b1, 8'd0, 32'h00221821}) begin errors++; $display("[TB] FAIL after_illegal got %b@%0d %h want 1@0 00221821", we, addr, data); end
    step();
    checks++; if ({error, count} !== {1'b1, 8'd1}) begin errors++; $display("[TB] FAIL error_sticky got err=%b cnt=%0d want 1/1", error, count); end
    pulse_start();
    checks++; if ({error, count} !== {1'b0, 8'd0}) begin errors++; $display("[TB] FAIL start_clears got err=%b cnt=%0d want 0/0", error, count); end
  endtask

  task automatic test_restart_in_write();
    pulse_start();
    issue(5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    issue(5'd3, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0);
    step();
    issue(5'd4, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0);
    checks++; if ({we, addr} !== {1'b1, 8'd1}) begin errors++; $display("[TB] FAIL write_before_restart got %b@%0d want 1@1", we, addr); end
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    checks++; if ({we, ready, error, count} !== {3'b010, 8'd0}) begin errors++; $display("[TB] FAIL restart_in_write got we=%b rdy=%b err=%b cnt=%0d want 0/1/0/0", we, ready, error, count); end
    issue(5'd5, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0);
    checks++; if (addr !== 8'd0) begin errors++; $display("[TB] FAIL restart_addr got %0d want 0", addr); end
    step();
  endtask

  task automatic test_halt();
    pulse_start();
    issue(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    step();
    i_done = 1'b1;
    issue(5'd3, 5'd9, 5'd10, 5'd11, 5'd0, 16'h0, 26'h0);
    checks++; if ({we, addr, data} !== {1'b1, 8'd1, ref_encode(3, 5'd9, 5'd10, 5'd11, 5'd0, 16'h0, 26'h0)}) begin errors++; $display("[TB] FAIL valid_with_done got %b@%0d %h", we, addr, data); end
    step();
    step();
    checks++; if ({we, addr, data} !== {1'b1, 8'd2, HALT}) begin errors++; $display("[TB] FAIL halt_write got %b@%0d %h want 1@2 FFFFFFFF", we, addr, data); end
    i_done = 1'b0;
    step();
    checks++; if ({we, busy, load_done, count} !== {3'b001, 8'd2}) begin errors++; $display("[TB] FAIL done_state got we=%b busy=%b done=%b cnt=%0d want 0/0/1/2", we, busy, load_done, count); end
    step();
    checks++; if (load_done !== 1'b1) begin errors++; $display("[TB] FAIL done_hold got %b want 1", load_done); end
    pulse_start();
    checks++; if ({busy, load_done, count} !== {2'b10, 8'd0}) begin errors++; $display("[TB] FAIL reload got busy=%b done=%b cnt=%0d want 1/0/0", busy, load_done, count); end
    issue(5'd1, 5'd2, 5'd3, 5'd4, 5'd0, 16'h0, 26'h0);
    checks++; if ({we, addr} !== {1'b1, 8'd0}) begin errors++; $display("[TB] FAIL reload_addr got %b@%0d want 1@0", we, addr); end
    step();
  endtask

  task automatic test_random();
    int n_ok = 0;
    logic err_m = 1'b0;
    logic [4:0] mn, rs, rt, rd, sh;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] exp;
    pulse_start();
    for (int k = 0; k < 30; k++) begin
      mn = (k == 7) ? 5'd31 : 5'($urandom_range(0, 31));
      rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); sh = 5'($urandom);
      imm = 16'($urandom); tgt = 26'($urandom);
      issue(mn, rs, rt, rd, sh, imm, tgt);
      if (mn == 5'd31) begin
        err_m = 1'b1;
        checks++; if ({we, error} !== 2'b01) begin errors++; $display("[TB] FAIL rand_illegal k=%0d got we=%b err=%b want 0/1", k, we, error); end
      end else begin
        exp = ref_encode(int'(mn), rs, rt, rd, sh, imm, tgt);
        checks++; if ({we, addr, data} !== {1'b1, 8'(n_ok), exp}) begin errors++; $display("[TB] FAIL rand_write k=%0d mn=%0d got %b@%0d %h want 1@%0d %h", k, mn, we, addr, data, n_ok, exp); end
        n_ok++;
        step();
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    checks++; if ({error, count} !== {err_m, 8'(n_ok)}) begin errors++; $display("[TB] FAIL rand_totals got err=%b cnt=%0d want %b/%0d", error, count, err_m, n_ok); end
    @(negedge clk); i_done = 1'b1;
    step();
    i_done = 1'b0;
    checks++; if ({we, addr, data} !== {1'b1, 8'(n_ok), HALT}) begin errors++; $display("[TB] FAIL rand_halt got %b@%0d %h want 1@%0d FFFFFFFF", we, addr, data, n_ok); end
    step();
  endtask

  task automatic test_overflow();
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      issue(5'd0, 5'(k), 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
      checks++; if ({s_we, s_addr} !== {1'b1, 2'(k)}) begin errors++; $display("[TB] FAIL small_write k=%0d got %b@%0d want 1@%0d", k, s_we, s_addr, k); end
      step();
    end
    checks++; if ({s_ready, s_count, s_error} !== {1'b0, 2'd3, 1'b0}) begin errors++; $display("[TB] FAIL small_full got rdy=%b cnt=%0d err=%b want 0/3/0", s_ready, s_count, s_error); end
    issue(5'd0, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0);
    checks++; if ({s_we, s_error, s_count} !== {2'b01, 2'd3}) begin errors++; $display("[TB] FAIL overflow got we=%b err=%b cnt=%0d want 0/1/3", s_we, s_error, s_count); end
    step();
    @(negedge clk); i_done = 1'b1;
    step();
    i_done = 1'b0;
    checks++; if ({s_we, s_addr, s_data} !== {1'b1, 2'd3, HALT}) begin errors++; $display("[TB] FAIL small_halt got %b@%0d %h want 1@3 FFFFFFFF", s_we, s_addr, s_data); end
    step();
    checks++; if ({s_load_done, s_count, s_error} !== {1'b1, 2'd3, 1'b1}) begin errors++; $display("[TB] FAIL small_done got done=%b cnt=%0d err=%b want 1/3/1", s_load_done, s_count, s_error); end
  endtask

  initial begin
    test_reset();
    test_encode();
    test_illegal();
    test_restart_in_write();
    test_halt();
    test_random();
    test_overflow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
